// File: rtl/wr_tx_queue_if.sv
// rtl/wr_tx_queue_if.sv - push, transmit handshake and status bundle for wr_tx_queue
interface wr_tx_queue_if;
  logic       in_en;
  logic [7:0] in_data;
  logic       flush;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  modport master (
    output in_en, in_data, flush, tx_busy,
    input  tx_en, tx_data, full, empty, overflow, timeout_err, drop_cnt
  );

  modport slave (
    input  in_en, in_data, flush, tx_busy,
    output tx_en, tx_data, full, empty, overflow, timeout_err, drop_cnt
  );
endinterface

// File: rtl/wr_tx_queue.sv
// rtl/wr_tx_queue.sv - byte FIFO plus en/busy transmit sequencer in front of cy_tx
// Define TX_QUEUE_STATS_EN to implement the saturating drop_cnt counter.
module wr_tx_queue #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  wr_tx_queue_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q;
  logic                  overflow_q, overflow_d, timeout_q, timeout_d;
  logic                  tx_en_q, tx_en_d;
  logic [7:0]            tx_data_q, tx_data_d, timer_q, timer_d;
  logic                  pop, push_ok, drop;

  // A pop frees a slot on the same edge, so a full queue still accepts that push.
  assign pop     = (state_q == IDLE) && !empty_q;
  assign push_ok = bus.in_en && !bus.flush && (!full_q || pop);
  assign drop    = bus.in_en && !push_ok;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (bus.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          tx_data_d = mem[rd_ptr_q];
          tx_en_d   = 1'b1;
          timer_d   = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bus.tx_busy) begin
          tx_en_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (timer_q == 8'(BUSY_TIMEOUT - 1)) begin
          tx_en_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      timer_q    <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.in_data;
  end

`ifdef TX_QUEUE_STATS_EN
  logic [7:0] drop_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
  end
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif

  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_wr_tx_queue.sv
// tb/tb_wr_tx_queue.sv - directed self-checking bench for wr_tx_queue
module tb_wr_tx_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wr_tx_queue_if bus();
  wr_tx_queue #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef TX_QUEUE_STATS_EN
  localparam logic [7:0] DROP_ONE = 8'd1;
`else
  localparam logic [7:0] DROP_ONE = 8'd0;
`endif

  int checks = 0;
  int failures = 0;

  // cy_tx stand-in: busy rises one negedge after tx_en is seen, stays high 20 cycles
  logic       model_on = 1'b0;
  logic       busy_model = 1'b0;
  logic       busy_manual = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] frames [$];

  assign bus.tx_busy = model_on ? busy_model : busy_manual;

  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy_model = 1'b0;
    end else if (model_on && bus.tx_en) begin
      busy_model = 1'b1;
      busy_cnt = 20;
      frames.push_back(bus.tx_data);
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(bus.empty && !bus.tx_en && busy_cnt == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n >= limit) begin failures++; $display("FAIL drain_timeout waited=%0d limit=%0d", n, limit); end
  endtask

  task automatic do_reset();
    int n = 0;
    while (busy_cnt != 0 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_en = 1'b0;
    bus.flush = 1'b0;
    bus.in_data = 8'h00;
    model_on = 1'b0;
    busy_manual = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames.delete();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_data = d;
    @(negedge clk);
    bus.in_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en act=%0b exp=0", bus.tx_en); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data act=%0h exp=00", bus.tx_data); end
    checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b1) begin failures++; $display("FAIL reset_full_empty act=%0b%0b exp=01", bus.full, bus.empty); end
    checks++; if (bus.overflow !== 1'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_sticky act=%0b%0b exp=00", bus.overflow, bus.timeout_err); end
    checks++; if (bus.drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop_cnt act=%0d exp=0", bus.drop_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    model_on = 1'b1;
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_data = 8'h55;
    @(negedge clk);
    bus.in_en = 1'b0;
    checks++; if (bus.empty !== 1'b0 || bus.tx_en !== 1'b0) begin failures++; $display("FAIL single_after_push empty/tx_en act=%0b%0b exp=00", bus.empty, bus.tx_en); end
    @(negedge clk);
    checks++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h55) begin failures++; $display("FAIL single_tx_en act=%0b/%0h exp=1/55", bus.tx_en, bus.tx_data); end
    wait_idle(200);
    checks++; if (frames.size() != 1) begin failures++; $display("FAIL single_frame_count act=%0d exp=1", frames.size()); end
    else begin
      checks++; if (frames[0] !== 8'h55) begin failures++; $display("FAIL single_frame_data act=%0h exp=55", frames[0]); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty act=%0b exp=1", bus.empty); end
  endtask

  task automatic test_burst_full();
    do_reset();
    busy_manual = 1'b1;
    push(8'hA5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL burst_full_at_15 act=%0b exp=0", bus.full); end
      end
      bus.in_en = 1'b1;
      bus.in_data = 8'(i);
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin failures++; $display("FAIL burst_full_at_16 full/empty act=%0b%0b exp=10", bus.full, bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL burst_no_overflow act=%0b exp=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_data = 8'hEE;
    @(negedge clk);
    bus.in_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag act=%0b exp=1", bus.overflow); end
    checks++; if (bus.drop_cnt !== DROP_ONE) begin failures++; $display("FAIL ovf_drop_cnt act=%0d exp=%0d", bus.drop_cnt, DROP_ONE); end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ovf_full act=%0b exp=1", bus.full); end
    frames.delete();
    busy_manual = 1'b0;
    model_on = 1'b1;
    wait_idle(1000);
    checks++; if (frames.size() != 16) begin failures++; $display("FAIL ovf_frame_count act=%0d exp=16", frames.size()); end
    for (int i = 0; i < frames.size() && i < 16; i++) begin
      checks++; if (frames[i] !== 8'(i)) begin failures++; $display("FAIL ovf_frame_order idx=%0d act=%0h exp=%0h", i, frames[i], i); end
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    busy_manual = 1'b1;
    push(8'hA5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.in_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    busy_manual = 1'b0;
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_data = 8'h20;
    @(negedge clk);
    bus.in_en = 1'b0;
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL pp_full act=%0b exp=1", bus.full); end
    checks++; if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'h00) begin failures++; $display("FAIL pp_no_drop ovf/cnt act=%0b/%0d exp=0/0", bus.overflow, bus.drop_cnt); end
    checks++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h10) begin failures++; $display("FAIL pp_tx act=%0b/%0h exp=1/10", bus.tx_en, bus.tx_data); end
    frames.delete();
    model_on = 1'b1;
    wait_idle(1000);
    checks++; if (frames.size() != 17) begin failures++; $display("FAIL pp_frame_count act=%0d exp=17", frames.size()); end
    for (int i = 0; i < frames.size() && i < 17; i++) begin
      logic [7:0] e;
      e = 8'h10 + 8'(i);
      checks++; if (frames[i] !== e) begin failures++; $display("FAIL pp_frame_order idx=%0d act=%0h exp=%0h", i, frames[i], e); end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_data = 8'h31;
    @(negedge clk);
    bus.in_data = 8'h32;
    @(negedge clk);
    bus.in_en = 1'b0;
    checks++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h31 || bus.timeout_err !== 1'b0) begin
      failures++; $display("FAIL to_start tx_en/data/err act=%0b/%0h/%0b exp=1/31/0", bus.tx_en, bus.tx_data, bus.timeout_err); end
    while (bus.tx_en === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 255) begin failures++; $display("FAIL to_en_cycles act=%0d exp=255", n); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL to_err act=%0b exp=1", bus.timeout_err); end
    @(negedge clk);
    checks++; if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h32) begin failures++; $display("FAIL to_next act=%0b/%0h exp=1/32", bus.tx_en, bus.tx_data); end
    frames.delete();
    model_on = 1'b1;
    wait_idle(200);
    checks++; if (frames.size() != 1 || frames[0] !== 8'h32) begin failures++; $display("FAIL to_next_frame count=%0d exp=1 (byte 32)", frames.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    model_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.in_data = 8'h41 + 8'(i);
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL fl_pre_empty act=%0b exp=0", bus.empty); end
    bus.flush = 1'b1;
    bus.in_en = 1'b1;
    bus.in_data = 8'h46;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_en = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fl_empty act=%0b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b1 || bus.drop_cnt !== DROP_ONE) begin failures++; $display("FAIL fl_drop ovf/cnt act=%0b/%0d exp=1/%0d", bus.overflow, bus.drop_cnt, DROP_ONE); end
    wait_idle(200);
    checks++; if (frames.size() != 1) begin failures++; $display("FAIL fl_frame_count act=%0d exp=1", frames.size()); end
    else begin
      checks++; if (frames[0] !== 8'h41) begin failures++; $display("FAIL fl_frame_data act=%0h exp=41", frames[0]); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.in_data = 8'h50 + 8'(i);
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    while (bus.tx_en !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.tx_en !== 1'b1) begin failures++; $display("FAIL ar_pre_tx_en act=%0b exp=1", bus.tx_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_en !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL ar_tx act=%0b/%0h exp=0/00", bus.tx_en, bus.tx_data); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL ar_empty_full act=%0b%0b exp=10", bus.empty, bus.full); end
    checks++; if (bus.overflow !== 1'b0 || bus.timeout_err !== 1'b0 || bus.drop_cnt !== 8'h00) begin
      failures++; $display("FAIL ar_sticky ovf/err/cnt act=%0b/%0b/%0d exp=0/0/0", bus.overflow, bus.timeout_err, bus.drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy_cnt != 0 && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    bus.in_en = 1'b0;
    bus.in_data = 8'h00;
    bus.flush = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_burst_full();
    test_overflow();
    test_push_pop_full();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wr_tx_queue.md
# wr_tx_queue

Byte queue and transmit sequencer between the command handlers (merged `txen`/`txdata`) and the UART transmitter `cy_tx`. It replaces the single-cycle priority mux hand-off, so handler bytes written while `cy_tx` is busy are not lost. Bytes are stored in a circular FIFO and presented one at a time to `cy_tx` under the en/busy handshake.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `BUSY_TIMEOUT`, 255: cycles to wait for `tx_busy` after `tx_en` before abandoning the byte (8-bit counter, 1..255).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_en`  in  1  push strobe, one byte per cycle high.
- `in_data`  in  8  byte to push.
- `flush`  in  1  synchronous clear of queued (not in-flight) bytes.
- `tx_busy`  in  1  `busy` from `cy_tx`.
- `tx_en`  out  1  start request to `cy_tx`.
- `tx_data`  out  8  byte to `cy_tx`, stable while `tx_en`=1.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky: a push was dropped.
- `timeout_err`  out  1  sticky: a byte was abandoned after `BUSY_TIMEOUT`.
- `drop_cnt`  out  8  dropped-push counter (only with `TX_QUEUE_STATS_EN`).

## Operation
- Storage: `mem[2^DEPTH_LOG2]`, `wr_ptr`/`rd_ptr` DEPTH_LOG2 bits, wrap modulo depth; `count` DEPTH_LOG2+1 bits.
- Push accepted when `in_en` && (!full || pop in same cycle); write `mem[wr_ptr]`, `wr_ptr`+1.
- Full, no pop: byte dropped, `overflow`<=1, `drop_cnt` saturating +1.
- `flush`: `rd_ptr`<=`wr_ptr`, `count`<=0; a push in the same cycle is discarded and counts as a drop; the in-flight byte is unaffected.
- State machine:
  - IDLE: if !empty -> pop `mem[rd_ptr]` into `tx_data`, `rd_ptr`+1, `tx_en`<=1, go START.
  - START: `tx_en` held 1; if `tx_busy` -> `tx_en`<=0, go WAIT_DONE. Else timer+1; at `BUSY_TIMEOUT` -> `tx_en`<=0, `timeout_err`<=1, go IDLE (byte lost).
  - WAIT_DONE: when `tx_busy`==0 -> IDLE.
- `overflow` and `timeout_err` clear only on reset.

## Timing
- Reset (async assert, synchronous deassert handled upstream): `tx_en`=0, `tx_data`=0, `full`=0, `empty`=1, `overflow`=0, `timeout_err`=0, `drop_cnt`=0, pointers 0, state IDLE.
- Push at edge N into empty queue: `empty`=0 after N; `tx_en`=1 after edge N+1 (2-cycle latency from `in_en` high to `tx_en` high).
- `tx_en` drops on the edge after `tx_busy` is sampled high. Minimum gap between bytes is `tx_busy` fall, then 1 cycle in IDLE, then `tx_en`.
- `full`/`empty` registered, reflect count after the current edge.
- Simultaneous push and pop: count unchanged. Push while full with pop in same cycle is accepted.
- Reset mid-transfer: `tx_en` drops immediately and queue contents are lost. The `cy_tx` frame in progress completes on its own.

## Configuration
- `TX_QUEUE_STATS_EN` defined: `drop_cnt` implemented, 8-bit saturating at 255, reset 0.
- Not defined: `drop_cnt` tied to 0 and no counter logic is synthesized. `overflow` remains in both builds.

## Test plan
- Reset, then push 0x55 with `tx_busy` model (busy 1 cycle after en, 20 cycles long) -> `tx_en` high 2 cycles after push, `tx_data`=0x55, exactly one frame sent, `empty`=1.
- Burst push 0x00..0x0F back-to-back while `tx_busy` held high -> `full`=1 after the 16th push. Release busy -> 16 frames in order 0x00..0x0F.
- Push 17 bytes while the sequencer is stalled -> 17th dropped, `overflow`=1, `drop_cnt`=1 (stats build) / 0 (no stats). 16 bytes are still delivered.
- Queue full, push on the cycle IDLE pops -> push accepted, `count` stays 16, no drop.
- `tx_busy` stuck 0 -> `tx_en` deasserts after 255 cycles, `timeout_err`=1, next byte issued.
- Queue 5 bytes, assert `flush` during byte 1 frame -> byte 1 completes, bytes 2-5 never sent, `empty`=1. Assert `rst_n`=0 mid-frame -> all outputs reach reset values without waiting for a clock edge.
